aes192_iter_ctrl: RTL

Iterative AES-192 encryption controller. Accepts one plaintext block and one 192-bit key over a valid/ready handshake, then runs the 12 AES-192 rounds on a single shared round datapath, one round per clock. Round keys are expanded on the fly from a 6-word sliding window, so the full 1664-bit schedule is never stored. Used where the area of the fully unrolled 12-round encryptor is not affordable; the combinational SubBytes, ShiftRows, MixColumns and AddRoundKey blocks are reused unchanged.

---
 rtl/aes192_iter_ctrl_if.sv | 21 ++
 rtl/aes192_iter_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes192_iter_ctrl_if.sv
// Block handshake bundle for aes192_iter_ctrl.
// Plaintext/key in on one valid/ready pair, ciphertext out on the other.
interface aes192_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] PlainText;
  logic [191:0] Key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] Encryption;

  modport master (
    output in_valid, PlainText, Key, out_ready,
    input  in_ready, out_valid, Encryption
  );

  modport slave (
    input  in_valid, PlainText, Key, out_ready,
    output in_ready, out_valid, Encryption
  );
endinterface

// File: rtl/aes192_iter_ctrl.sv
// Iterative AES-192 encryptor, one round per clock, on-the-fly key schedule.
// Optional `AES192_ITER_ABORT_EN adds an abort input.
module aes192_iter_ctrl (
  input  logic clk,
  input  logic rst_n,
  aes192_iter_ctrl_if.slave bus,
`ifdef AES192_ITER_ABORT_EN
  input  logic abort,
`endif
  output logic       busy,
  output logic [3:0] round
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [191:0] k_q, k_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] enc_q, enc_d;
  logic         ab;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = gmul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mixcols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
      };
    end
    return o;
  endfunction

  // w[i] = w[i-6] ^ t, with the SubWord/Rcon term every sixth word
  function automatic logic [31:0] kw(
    input logic [31:0] prev,
    input logic [31:0] old,
    input logic [6:0]  i
  );
    logic [31:0] t;
    logic [6:0]  n;
    logic [7:0]  rc;
    t = prev;
    if (i % 7'd6 == 7'd0) begin
      n  = i / 7'd6;
      rc = 8'h01 << (n - 7'd1);
      t  = subword({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
    end
    return old ^ t;
  endfunction

`ifdef AES192_ITER_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  logic [127:0] sr, mc, rnd_out;
  logic [6:0]   ix;
  logic [31:0]  n0, n1, n2, n3, w6, w7;

  always_comb begin
    sr      = sub_shift(s_q);
    mc      = mixcols(sr);
    rnd_out = ((rnd_q == 4'd12) ? sr : mc) ^ k_q[127:0];
    ix      = {1'b0, rnd_q, 2'b00} + 7'd4;
    n0      = kw(k_q[31:0], k_q[191:160], ix);
    n1      = kw(n0, k_q[159:128], ix + 7'd1);
    n2      = kw(n1, k_q[127:96],  ix + 7'd2);
    n3      = kw(n2, k_q[95:64],   ix + 7'd3);
    w6      = kw(bus.Key[31:0], bus.Key[191:160], 7'd6);
    w7      = kw(w6, bus.Key[159:128], 7'd7);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    enc_d   = enc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && !ab) begin
          state_d = ROUND;
          s_d     = bus.PlainText ^ bus.Key[191:64];
          k_d     = {bus.Key[127:0], w6, w7};
          rnd_d   = 4'd1;
        end
      end
      ROUND: begin
        s_d = rnd_out;
        k_d = {k_q[63:0], n0, n1, n2, n3};
        if (rnd_q == 4'd12) begin
          state_d = DONE;
          enc_d   = rnd_out;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ab && state_q != IDLE) begin
      state_d = IDLE;
      rnd_d   = 4'd0;
      enc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rnd_q   <= 4'd0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rnd_q   <= rnd_d;
      enc_q   <= enc_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.Encryption = enc_q;
  assign busy           = (state_q == ROUND);
  assign round          = rnd_q;
endmodule
